// File: rtl/imm_rotate_encoder.sv
// imm_rotate_encoder: multi-cycle inverse of the rotate-immediate shifter.
// Searches rotations r = 0..15 for the smallest r such that
// ROL(value, 2*r) fits in 8 bits, giving value == ROR(imm8, 2*r).
// One candidate is tested per cycle; results are registered on done.
module imm_rotate_encoder #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        c_in,
    output logic        busy,
    output logic        done,
    output logic        encodable,
    output logic [7:0]  imm8,
    output logic [3:0]  rot4,
    output logic        carry_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] val;        // latched operand
    logic        cin_l;      // latched carry-in
    logic [3:0]  r;          // rotation counter
    logic        found;      // a match has already been seen (full-scan mode)
    logic [7:0]  found_imm;
    logic [3:0]  found_r;

    logic [4:0]  shamt;
    logic [31:0] cand;
    logic        match;
    logic        finish;
    logic        res_hit;
    logic [7:0]  res_imm;
    logic [3:0]  res_rot;

    // Bit 31 of ROR(imm, 2*rot): that is imm bit (2*rot - 1), which only
    // exists inside the byte for small rotations. rot == 0 keeps the old C.
    function automatic logic carry_for(input logic [7:0] imm,
                                       input logic [3:0] rot,
                                       input logic       cin);
        logic [4:0] idx;
        idx = {rot, 1'b0} - 5'd1;
        if (rot == 4'd0)
            return cin;
        else if (idx < 5'd8)
            return imm[idx[2:0]];
        else
            return 1'b0;
    endfunction

    // Candidate generation and the result selected if the search ends now.
    always_comb begin
        shamt   = {r, 1'b0};
        // A shift of 32 yields zero, so shamt == 0 returns val unchanged.
        cand    = (val << shamt) | (val >> (6'd32 - {1'b0, shamt}));
        match   = (cand[31:8] == 24'd0);
        finish  = EARLY_EXIT ? (match || (r == 4'd15)) : (r == 4'd15);
        res_hit = EARLY_EXIT ? match : (found || match);
        res_imm = (!EARLY_EXIT && found) ? found_imm : cand[7:0];
        res_rot = (!EARLY_EXIT && found) ? found_r   : r;
    end

    // Control FSM with registered outputs; results only change on done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            encodable <= 1'b0;
            imm8      <= 8'd0;
            rot4      <= 4'd0;
            carry_out <= 1'b0;
            r         <= 4'd0;
            found     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        val   <= value;
                        cin_l <= c_in;
                        r     <= 4'd0;
                        found <= 1'b0;
                        busy  <= 1'b1;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (finish) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        encodable <= res_hit;
                        imm8      <= res_hit ? res_imm : 8'd0;
                        rot4      <= res_hit ? res_rot : 4'd0;
                        carry_out <= res_hit ? carry_for(res_imm, res_rot, cin_l) : cin_l;
                        state     <= DONE;
                    end else begin
                        // Keep only the first hit so the smallest rotation wins.
                        if (!found && match) begin
                            found     <= 1'b1;
                            found_imm <= cand[7:0];
                            found_r   <= r;
                        end
                        r <= r + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Testbench for imm_rotate_encoder: an early-exit instance (index 0) and a
// full-scan instance (index 1) share stimulus and are compared against an
// arithmetic reference of the rotate-immediate encoding.
module tb_imm_rotate_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        c_in;

    logic        busy_o [2];
    logic        done_o [2];
    logic        enc_o  [2];
    logic [7:0]  imm_o  [2];
    logic [3:0]  rot_o  [2];
    logic        cy_o   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imm_rotate_encoder #(.EARLY_EXIT(1'b1)) dut_early (
        .clk(clk), .reset(reset), .start(start), .value(value), .c_in(c_in),
        .busy(busy_o[0]), .done(done_o[0]), .encodable(enc_o[0]),
        .imm8(imm_o[0]), .rot4(rot_o[0]), .carry_out(cy_o[0])
    );

    imm_rotate_encoder #(.EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .reset(reset), .start(start), .value(value), .c_in(c_in),
        .busy(busy_o[1]), .done(done_o[1]), .encodable(enc_o[1]),
        .imm8(imm_o[1]), .rot4(rot_o[1]), .carry_out(cy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rol_n(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
        return t;
    endfunction

    function automatic logic [31:0] ror_n(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < n; i++) t = {t[0], t[31:1]};
        return t;
    endfunction

    // Reference: smallest rotation whose left-rotated value fits in a byte.
    task automatic model(input logic [31:0] v, input logic c,
                         output logic hit, output logic [7:0] imm,
                         output logic [3:0] rot, output logic cy);
        logic [31:0] cnd;
        hit = 1'b0; imm = 8'd0; rot = 4'd0; cy = c;
        for (int k = 0; k < 16; k++) begin
            cnd = rol_n(v, 2 * k);
            if (!hit && cnd < 32'h100) begin
                hit = 1'b1;
                imm = cnd[7:0];
                rot = 4'(k);
            end
        end
        if (hit && rot != 4'd0) begin
            cnd = ror_n({24'd0, imm}, 2 * int'(rot));
            cy  = cnd[31];
        end
    endtask

    // One request. mid_k: cycle in which an extra start (value 0xFF) is
    // driven while searching. rst_k: cycle in which reset is asserted.
    task automatic run_txn(input logic [31:0] v, input logic c, input int mid_k, input int rst_k);
        int          done_cnt [2];
        int          done_at  [2];
        int          busy_cnt [2];
        logic        cap_enc  [2];
        logic [7:0]  cap_imm  [2];
        logic [3:0]  cap_rot  [2];
        logic        cap_cy   [2];
        logic        e_hit, e_cy;
        logic [7:0]  e_imm;
        logic [3:0]  e_rot;
        int          lat;
        model(v, c, e_hit, e_imm, e_rot, e_cy);
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = 0; done_at[d] = 0; busy_cnt[d] = 0;
            cap_enc[d] = 1'b0; cap_imm[d] = 8'd0; cap_rot[d] = 4'd0; cap_cy[d] = 1'b0;
        end
        value = v; c_in = c; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rst_k != 0 && k == rst_k + 1) begin
                for (int d = 0; d < 2; d++) begin
                    check("rst_busy", 32'(busy_o[d]), 32'd0);
                    check("rst_done", 32'(done_o[d]), 32'd0);
                    check("rst_outs", {enc_o[d], imm_o[d], rot_o[d], cy_o[d]}, 32'd0);
                end
                reset = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                if (busy_o[d]) busy_cnt[d]++;
                if (done_o[d]) begin
                    done_cnt[d]++;
                    done_at[d] = k;
                    cap_enc[d] = enc_o[d]; cap_imm[d] = imm_o[d];
                    cap_rot[d] = rot_o[d]; cap_cy[d] = cy_o[d];
                end
            end
            if (k == 1) start = 1'b0;
            if (mid_k != 0 && k == mid_k) begin start = 1'b1; value = 32'h000000FF; end
            if (mid_k != 0 && k == mid_k + 1) start = 1'b0;
            if (rst_k != 0 && k == rst_k) reset = 1'b1;
        end
        if (rst_k != 0) begin
            for (int d = 0; d < 2; d++) check("no_done_after_rst", 32'(done_cnt[d]), 32'd0);
        end else begin
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0 && e_hit) ? int'(e_rot) + 2 : 17;
                check("done_count", 32'(done_cnt[d]), 32'd1);
                check("done_cycle", 32'(done_at[d]), 32'(lat));
                check("busy_cycles", 32'(busy_cnt[d]), 32'(lat - 1));
                check("encodable", 32'(cap_enc[d]), 32'(e_hit));
                check("imm8", 32'(cap_imm[d]), 32'(e_imm));
                check("rot4", 32'(cap_rot[d]), 32'(e_rot));
                check("carry_out", 32'(cap_cy[d]), 32'(e_cy));
                check("hold", {enc_o[d], imm_o[d], rot_o[d], cy_o[d]},
                      {18'd0, e_hit, e_imm, e_rot, e_cy});
            end
        end
    endtask

    // start held high: the early-exit instance restarts in the IDLE cycle
    // after each done, so a rotation-0 value gives done every third cycle.
    task automatic held_start();
        value = 32'h000000FF; c_in = 1'b0; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 9) check("held_done", 32'(done_o[0]), 32'((k % 3) == 2));
            if (k == 8) check("held_imm", 32'(imm_o[0]), 32'h000000FF);
            if (k == 17) check("held_full_done", 32'(done_o[1]), 32'd1);
            if (k == 9) start = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  im;
        int          rr;
        reset = 1'b1; start = 1'b0; value = 32'd0; c_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_busy", 32'(busy_o[d]), 32'd0);
            check("reset_done", 32'(done_o[d]), 32'd0);
            check("reset_outs", {enc_o[d], imm_o[d], rot_o[d], cy_o[d]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        run_txn(32'h000000FF, 1'b0, 0, 0);
        run_txn(32'hFF000000, 1'b0, 0, 0);
        run_txn(32'hF000000F, 1'b0, 0, 0);
        run_txn(32'h00000102, 1'b1, 0, 0);
        run_txn(32'h00000102, 1'b0, 3, 0);
        run_txn(32'h00000102, 1'b0, 0, 5);
        run_txn(32'h000000FF, 1'b0, 0, 0);
        run_txn(32'h3FC00000, 1'b0, 0, 0);
        run_txn(32'h00000000, 1'b1, 0, 0);
        run_txn(32'h80000001, 1'b0, 0, 0);
        held_start();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                im = 8'($urandom_range(0, 255));
                rr = int'($urandom_range(0, 15));
                v  = ror_n({24'd0, im}, 2 * rr);
            end else begin
                v = $urandom;
            end
            run_txn(v, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
